riscv_lsu: RTL and testbench



---
 rtl/riscv_pkg.sv | 24 ++
 rtl/riscv_lsu_align.sv | 90 +++++++++
 rtl/riscv_lsu.sv | 172 +++++++++++++++++
 tb/tb_riscv_lsu.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : riscv_pkg                                              |
// | Description : Shared load/store size encodings and LSU state type.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package riscv_pkg;

    // Access size encodings, shared with the instruction decoder
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    // Load-store unit sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/riscv_lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : riscv_lsu_align                                        |
// | Description : Combinational lane logic for the LSU: store lane       |
// |               replication, byte enables, load lane select/extension  |
// |               and misalignment / illegal-size detection.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module riscv_lsu_align (
    input  logic        we_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rd_i,
    output logic [3:0]  be_o,
    output logic [31:0] wd_o,
    output logic [31:0] rd_o,
    output logic        misaligned_o
);
    import riscv_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and half out of the bus word
    always_comb begin
        w_byte = rd_i[7:0];
        case (off_i)
            2'd0:    w_byte = rd_i[7:0];
            2'd1:    w_byte = rd_i[15:8];
            2'd2:    w_byte = rd_i[23:16];
            default: w_byte = rd_i[31:24];
        endcase
        w_half = off_i[1] ? rd_i[31:16] : rd_i[15:0];
    end

    // Legality check: alignment per size, unsigned sizes are load-only
    always_comb begin
        misaligned_o = 1'b0;
        case (size_i)
            LDST_B:  misaligned_o = 1'b0;
            LDST_H:  misaligned_o = off_i[0];
            LDST_W:  misaligned_o = (off_i != 2'b00);
            LDST_BU: misaligned_o = we_i;
            LDST_HU: misaligned_o = we_i | off_i[0];
            default: misaligned_o = 1'b1;
        endcase
    end

    // Load extension: signed sizes replicate the lane's top bit
    always_comb begin
        rd_o = '0;
        case (size_i)
            LDST_B:  rd_o = {{24{w_byte[7]}}, w_byte};
            LDST_BU: rd_o = {24'd0, w_byte};
            LDST_H:  rd_o = {{16{w_half[15]}}, w_half};
            LDST_HU: rd_o = {16'd0, w_half};
            LDST_W:  rd_o = rd_i;
            default: rd_o = '0;
        endcase
    end

    // Store lanes replicated so any byte/half position sees its data; loads read all lanes
    always_comb begin
        be_o = 4'b1111;
        wd_o = '0;
        if (we_i) begin
            case (size_i)
                LDST_B: begin
                    be_o = 4'b0001 << off_i;
                    wd_o = {4{wd_i[7:0]}};
                end
                LDST_H: begin
                    be_o = off_i[1] ? 4'b1100 : 4'b0011;
                    wd_o = {2{wd_i[15:0]}};
                end
                LDST_W: begin
                    be_o = 4'b1111;
                    wd_o = wd_i;
                end
                default: begin
                    be_o = 4'b0000;
                    wd_o = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : riscv_lsu                                              |
// | Description : Load-store unit. Turns a core memory request into a    |
// |               word-aligned byte-enabled bus access, stalls the core  |
// |               until the bus answers and returns extended load data.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        misaligned_o,
    output logic        timeout_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);
    import riscv_pkg::*;

    localparam int unsigned c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_to_limit = c_cnt_w'(TIMEOUT_CYCLES);

    lsu_state_t         state_q, state_d;
    logic               we_q, we_d;
    logic [2:0]         size_q, size_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wd_q, wd_d;
    logic [31:0]        rd_q, rd_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               mis_q, mis_d;
    logic               to_q, to_d;

    logic               w_idle, w_busy, w_done;
    logic               w_sel_we;
    logic [2:0]         w_sel_size;
    logic [1:0]         w_sel_off;
    logic [31:0]        w_sel_wd;
    logic [3:0]         w_be;
    logic [31:0]        w_wd;
    logic [31:0]        w_rd_ext;
    logic               w_mis;

    assign w_idle = (state_q == IDLE);
    assign w_busy = (state_q == BUSY);
    assign w_done = (state_q == DONE);

    // While idle the legality check looks at the live request; afterwards at the latched one
    assign w_sel_we   = w_idle ? core_we_i        : we_q;
    assign w_sel_size = w_idle ? core_size_i      : size_q;
    assign w_sel_off  = w_idle ? core_addr_i[1:0] : addr_q[1:0];
    assign w_sel_wd   = w_idle ? core_wd_i        : wd_q;

    riscv_lsu_align u_align (
        .we_i         (w_sel_we),
        .size_i       (w_sel_size),
        .off_i        (w_sel_off),
        .wd_i         (w_sel_wd),
        .rd_i         (mem_rd_i),
        .be_o         (w_be),
        .wd_o         (w_wd),
        .rd_o         (w_rd_ext),
        .misaligned_o (w_mis)
    );

    // State register and request latches
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            to_q    <= to_d;
        end
    end

    // Next-state: accept in IDLE, wait for ready or timeout in BUSY, commit in DONE
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    we_d   = core_we_i;
                    size_d = core_size_i;
                    addr_d = core_addr_i;
                    wd_d   = core_wd_i;
                    mis_d  = w_mis;
                    to_d   = 1'b0;
                    if (w_mis) begin
                        rd_d    = '0;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem_ready_i) begin
                    if (!we_q) begin
                        rd_d = w_rd_ext;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((TIMEOUT_CYCLES != 0) && (cnt_d == c_to_limit)) begin
                        to_d    = 1'b1;
                        rd_d    = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Core commits on this edge; a request still visible here is the next one
                cnt_d   = '0;
                mis_d   = 1'b0;
                to_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus side is only driven during BUSY so an async reset abandons it at once
    assign mem_req_o    = w_busy;
    assign mem_we_o     = w_busy & we_q;
    assign mem_be_o     = w_busy ? w_be : 4'b0000;
    assign mem_addr_o   = w_busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wd_o     = w_busy ? w_wd : 32'd0;

    assign core_stall_o = (w_idle & core_req_i) | w_busy;
    assign core_rd_o    = rd_q;
    assign misaligned_o = w_done & mis_q;
    assign timeout_o    = w_done & to_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_riscv_lsu                                           |
// | Description : Scoreboard bench for riscv_lsu with directed cases     |
// |               and randomized traffic against a behavioural model.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_riscv_lsu;

    localparam int TO = 4;

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic        core_req_i  = 1'b0;
    logic        core_we_i   = 1'b0;
    logic [2:0]  core_size_i = 3'd0;
    logic [31:0] core_addr_i = 32'd0;
    logic [31:0] core_wd_i   = 32'd0;
    logic [31:0] mem_rd_i    = 32'd0;
    logic        mem_ready_i = 1'b0;
    logic [31:0] core_rd_o;
    logic        core_stall_o, misaligned_o, timeout_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o;

    riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .misaligned_o (misaligned_o),
        .timeout_o    (timeout_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        mis;
        logic        to;
        logic [31:0] rd;
        int          stall;
    } cmp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } bus_t;

    cmp_t        sb_q[$];
    bus_t        bus_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd_model = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int access_bytes(input logic [2:0] sz);
        if (sz == 3'd0 || sz == 3'd4) return 1;
        if (sz == 3'd1 || sz == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic we, input logic [2:0] sz, input logic [31:0] a);
        bit illegal;
        illegal = (sz == 3'd3) || (sz == 3'd6) || (sz == 3'd7) || (we && sz >= 3'd4);
        return illegal || ((a % access_bytes(sz)) != 0);
    endfunction

    function automatic logic [31:0] model_ext(input logic [2:0] sz, input logic [31:0] a,
                                              input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] off;
        off = a % 4;
        if (access_bytes(sz) == 1) begin
            v = (rd >> (8 * off)) & 32'd255;
            if (sz == 3'd0 && v >= 32'd128) v = v - 32'd256;
        end else if (access_bytes(sz) == 2) begin
            off = (off / 2) * 2;
            v = (rd >> (8 * off)) & 32'hFFFF;
            if (sz == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] sz, input logic [31:0] a);
        if (!we) return 4'hF;
        if (access_bytes(sz) == 1) return 4'(1 << (a % 4));
        if (access_bytes(sz) == 2) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wd(input logic we, input logic [2:0] sz, input logic [31:0] wd);
        if (!we) return 32'd0;
        if (access_bytes(sz) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (access_bytes(sz) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // k = BUSY cycle in which ready is given (1 = first); 0 = never
    task automatic do_txn(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata, input int k);
        cmp_t e;
        bus_t b;
        bit   done;
        done  = 1'b0;
        e.mis = model_mis(we, sz, addr);
        e.to  = 1'b0;
        if (e.mis) begin
            rd_model = 32'd0;
            e.stall  = 1;
        end else begin
            b.addr = addr & 32'hFFFF_FFFC;
            b.be   = model_be(we, sz, addr);
            b.we   = we;
            b.wd   = model_wd(we, sz, wd);
            bus_q.push_back(b);
            if (k != 0 && k <= TO) begin
                if (!we) rd_model = model_ext(sz, addr, rdata);
                e.stall = 1 + k;
            end else begin
                e.to     = 1'b1;
                rd_model = 32'd0;
                e.stall  = 1 + TO;
            end
        end
        e.rd = rd_model;
        sb_q.push_back(e);

        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = addr;
        core_wd_i   = wd;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(posedge clk_i); #1;
            mem_ready_i = (c == k);
            mem_rd_i    = (c == k) ? rdata : $urandom;
            @(negedge clk_i);
            if (!core_stall_o) done = 1'b1;
        end
        check("txn_completes", {31'd0, done}, 32'd1);
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
    endtask

    // ---------------- monitor ----------------
    bit   mon_prev_stall = 1'b0;
    bit   mon_prev_req   = 1'b0;
    int   mon_stall_cnt  = 0;
    cmp_t mon_e;
    bus_t mon_b;

    // Pops expected results on each completion and checks bus fields each request cycle
    always @(negedge clk_i) begin
        if (rst_i) begin
            mon_prev_stall = 1'b0;
            mon_prev_req   = 1'b0;
            mon_stall_cnt  = 0;
        end else begin
            if (mon_prev_stall && !core_stall_o) begin
                if (sb_q.size() == 0) begin
                    check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("misaligned_o", {31'd0, misaligned_o}, {31'd0, mon_e.mis});
                    check("timeout_o", {31'd0, timeout_o}, {31'd0, mon_e.to});
                    check("core_rd_o", core_rd_o, mon_e.rd);
                    check("stall_cycles", 32'(mon_stall_cnt), 32'(mon_e.stall));
                end
            end else begin
                check("no_stray_pulse", {30'd0, misaligned_o, timeout_o}, 32'd0);
            end
            if (core_stall_o) mon_stall_cnt = mon_prev_stall ? mon_stall_cnt + 1 : 1;

            if (mem_req_o) begin
                if (!mon_prev_req) begin
                    if (bus_q.size() == 0) begin
                        check("bus_pending", 32'(bus_q.size() != 0), 32'd1);
                        mon_b.addr = 'x;
                    end else begin
                        mon_b = bus_q.pop_front();
                    end
                end
                check("mem_addr_o", mem_addr_o, mon_b.addr);
                check("mem_be_o", {28'd0, mem_be_o}, {28'd0, mon_b.be});
                check("mem_we_o", {31'd0, mem_we_o}, {31'd0, mon_b.we});
                check("mem_wd_o", mem_wd_o, mon_b.wd);
            end
            mon_prev_stall = core_stall_o;
            mon_prev_req   = mem_req_o;
        end
    end

    // ---------------- stimulus ----------------
    logic [2:0] sz_tab [11] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        logic [31:0] a;
        logic        we;
        logic [2:0]  sz;

        #2;
        check("rst_core_rd_o", core_rd_o, 32'd0);
        check("rst_stall", {31'd0, core_stall_o}, 32'd0);
        check("rst_pulses", {30'd0, misaligned_o, timeout_o}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_mem_wd", mem_wd_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // directed cases
        do_txn(1'b0, 3'd2, 32'h0000_0100, 32'd0,          32'hDEAD_BEEF, 1);
        do_txn(1'b1, 3'd0, 32'h0000_0203, 32'h1234_5678,  32'd0,         2);
        do_txn(1'b0, 3'd0, 32'h0000_0101, 32'd0,          32'h0000_8000, 1);
        do_txn(1'b0, 3'd4, 32'h0000_0101, 32'd0,          32'h0000_8000, 1);
        do_txn(1'b1, 3'd2, 32'h0000_0040, 32'hCAFE_F00D,  32'd0,         1);
        do_txn(1'b0, 3'd1, 32'h0000_0102, 32'd0,          32'hFFFE_0000, 2);
        do_txn(1'b0, 3'd2, 32'h0000_0102, 32'd0,          32'h1111_1111, 1);
        do_txn(1'b0, 3'd2, 32'h0000_0104, 32'd0,          32'h5555_AAAA, 0);
        do_txn(1'b0, 3'd2, 32'h0000_0108, 32'd0,          32'h7777_8888, 3);
        do_txn(1'b0, 3'd5, 32'h0000_0002, 32'd0,          32'h8001_0000, TO);
        do_txn(1'b1, 3'd4, 32'h0000_0010, 32'h0000_00FF,  32'd0,         1);

        // async reset in the second BUSY cycle of an unanswered load
        begin
            bus_t b;
            b.addr = 32'h0000_0300; b.be = 4'hF; b.we = 1'b0; b.wd = 32'd0;
            bus_q.push_back(b);
        end
        @(posedge clk_i); #1;
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h0000_0300;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("busy_before_rst", {31'd0, mem_req_o}, 32'd1);
        rst_i = 1'b1;
        core_req_i = 1'b0;
        #1;
        check("rst_drops_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_drops_stall", {31'd0, core_stall_o}, 32'd0);
        check("rst_drops_be", {28'd0, mem_be_o}, 32'd0);
        check("rst_clears_rd", core_rd_o, 32'd0);
        rd_model = 32'd0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        do_txn(1'b1, 3'd1, 32'h0000_0002, 32'h0000_ABCD, 32'd0, 1);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            sz = sz_tab[$urandom_range(0, 10)];
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & 32'hFFFF_FFFC;
            do_txn(we, sz, a, $urandom, $urandom, int'($urandom_range(0, 6)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk_i); #1;
                mem_ready_i = 1'($urandom_range(0, 1));
                mem_rd_i    = $urandom;
            end
            mem_ready_i = 1'b0;
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("bus_drained", 32'(bus_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
